risc_v_mike_boot_loader: RTL and testbench



---
 rtl/risc_v_mike_pkg.sv | 16 +
 rtl/risc_v_mike_uart_rx.sv | 70 +++++++
 rtl/risc_v_mike_boot_loader.sv | 120 ++++++++++++
 tb/tb_risc_v_mike_boot_loader.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/risc_v_mike_pkg.sv
// risc_v_mike_pkg: shared boot-loader types and constants (RISC_V_MIKE_BOOT_CHKSUM_EN adds the CHK state)
package risc_v_mike_pkg;
  localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef RISC_V_MIKE_BOOT_CHKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } boot_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
endpackage

// File: rtl/risc_v_mike_uart_rx.sv
// risc_v_mike_uart_rx: 8N1 receiver with 2-flop synchronizer, centre sampling and framing check
module risc_v_mike_uart_rx
  import risc_v_mike_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  rx_state_t state, state_n;
  logic rx_m, rx_s, rx_p;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic tick;
  assign tick = cnt == ((state == RX_START) ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1));
  assign byte_data = shift;
  // synchronizer, edge-detect history and receiver state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
      state <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_idx_n;
      shift <= shift_n;
    end
  end
  // start-bit recheck at half bit, then one sample per bit centre, LSB first
  always_comb begin
    state_n = state;
    cnt_n = tick ? '0 : cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n = shift;
    byte_valid = 1'b0;
    frame_err = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        bit_idx_n = '0;
        if (rx_p && !rx_s) state_n = RX_START;
      end
      RX_START: if (tick) state_n = rx_s ? RX_IDLE : RX_BITS;
      RX_BITS: if (tick) begin
        shift_n = {rx_s, shift[7:1]};
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = RX_STOP;
      end
      default: if (tick) begin
        byte_valid = rx_s;
        frame_err = !rx_s;
        state_n = RX_IDLE;
      end
    endcase
  end
endmodule

// File: rtl/risc_v_mike_boot_loader.sv
// risc_v_mike_boot_loader: UART program loader into imem, holds core in reset until done (RISC_V_MIKE_BOOT_CHKSUM_EN enables trailing XOR byte)
module risc_v_mike_boot_loader
  import risc_v_mike_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int IMEM_ADDR_W = 8,
  parameter int BASE_WORD   = 2,
  parameter int TIMEOUT_CYC = 16 * (CLK_FREQ_HZ / BAUD_RATE) * 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   core_rst,
  output logic                   boot_done,
  output logic                   boot_err
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam logic [16:0] MAX_LEN = 17'((1 << IMEM_ADDR_W) - BASE_WORD);
`ifdef RISC_V_MIKE_BOOT_CHKSUM_EN
  localparam boot_state_t POST_DATA = CHK;
`else
  localparam boot_state_t POST_DATA = DONE;
`endif
  boot_state_t state, state_n;
  logic byte_valid, frame_err;
  logic [7:0] byte_data;
  logic [15:0] len, word_idx;
  logic [1:0] byte_cnt;
  logic [23:0] wbuf;
  logic [31:0] tmo;
  logic active, sync, timeout, word_end;
  risc_v_mike_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .frame_err(frame_err)
  );
`ifdef RISC_V_MIKE_BOOT_CHKSUM_EN
  logic [7:0] chk;
  assign active = state inside {LEN_LO, LEN_HI, DATA, CHK};
`else
  assign active = state inside {LEN_LO, LEN_HI, DATA};
`endif
  assign sync = byte_valid && byte_data == BOOT_SYNC_BYTE && state inside {IDLE, ERR};
  assign timeout = active && !byte_valid && tmo == 32'(TIMEOUT_CYC - 1);
  assign word_end = state == DATA && byte_valid && byte_cnt == 2'd3;
  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  // next state: errors first, then byte-driven progress; DATA exits once the last word's write is out
  always_comb begin
    state_n = state;
    if (frame_err && state != IDLE && state != DONE) state_n = ERR;
    else if (timeout) state_n = ERR;
    else case (state)
      IDLE, ERR: if (sync) state_n = LEN_LO;
      LEN_LO: if (byte_valid) state_n = LEN_HI;
      LEN_HI: if (byte_valid)
        state_n = ({1'b0, byte_data, len[7:0]} > MAX_LEN) ? ERR :
                  ({byte_data, len[7:0]} == 16'd0) ? POST_DATA : DATA;
      DATA: if (imem_we && word_idx == len) state_n = POST_DATA;
`ifdef RISC_V_MIKE_BOOT_CHKSUM_EN
      CHK: if (byte_valid) state_n = (byte_data == chk) ? DONE : ERR;
`endif
      default: ;
    endcase
  end
  // length capture, word assembly, memory write port, timeout and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      core_rst <= 1'b0;
      boot_done <= 1'b0;
      boot_err <= 1'b0;
      len <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      wbuf <= '0;
      tmo <= '0;
`ifdef RISC_V_MIKE_BOOT_CHKSUM_EN
      chk <= '0;
`endif
    end else begin
      imem_we <= word_end;
      core_rst <= state == DONE;
      boot_done <= state == DONE;
      boot_err <= state == ERR;
      tmo <= (active && !byte_valid) ? tmo + 32'd1 : '0;
      if (sync) begin
        word_idx <= '0;
        byte_cnt <= '0;
      end
      if (byte_valid && state == LEN_LO) len[7:0] <= byte_data;
      if (byte_valid && state == LEN_HI) len[15:8] <= byte_data;
      if (byte_valid && state == DATA) begin
        byte_cnt <= byte_cnt + 2'd1;
        wbuf <= {byte_data, wbuf[23:8]};
      end
      if (word_end) begin
        imem_addr <= IMEM_ADDR_W'(BASE_WORD) + word_idx[IMEM_ADDR_W-1:0];
        imem_wdata <= {byte_data, wbuf};
        word_idx <= word_idx + 16'd1;
      end
`ifdef RISC_V_MIKE_BOOT_CHKSUM_EN
      if (sync) chk <= '0;
      else if (byte_valid && state inside {LEN_LO, LEN_HI, DATA}) chk <= chk ^ byte_data;
`endif
    end
  end
endmodule

// File: tb/tb_risc_v_mike_boot_loader.sv
// tb_risc_v_mike_boot_loader: directed frame vectors against hand-computed loads and status
module tb_risc_v_mike_boot_loader;
  localparam int CPB = 16;
  localparam int TMO = 16 * CPB * 10;
  logic clk, rst, rx;
  logic imem_we, core_rst, boot_done, boot_err;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  int n_cmp, n_bad, we_total, base;
  logic [7:0] wa [8];
  logic [31:0] wd [8];
  logic [7:0] frame [12] = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'h13, 8'h01, 8'h40, 8'h00, 8'hE3};
  risc_v_mike_boot_loader #(
    .CLK_FREQ_HZ(1_600_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst(core_rst),
    .boot_done(boot_done),
    .boot_err(boot_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial we_total = 0;
  always @(negedge clk) if (imem_we) begin
    wa[we_total % 8] = imem_addr;
    wd[we_total % 8] = imem_wdata;
    we_total = we_total + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic send_frame(input int n, input int bad_idx);
    for (int i = 0; i < n; i++) send_byte(frame[i], i != bad_idx);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    base = we_total;
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rx = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", {31'd0, imem_we}, 0);
    check("rst_addr", {24'd0, imem_addr}, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_core_rst", {31'd0, core_rst}, 0);
    check("rst_done", {31'd0, boot_done}, 0);
    check("rst_err", {31'd0, boot_err}, 0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    base = we_total;
    send_frame(12, -1);
    repeat (20) @(negedge clk);
    check("ok_we_count", we_total - base, 2);
    check("ok_addr0", {24'd0, wa[base % 8]}, 2);
    check("ok_data0", wd[base % 8], 32'h0020_0093);
    check("ok_addr1", {24'd0, wa[(base + 1) % 8]}, 3);
    check("ok_data1", wd[(base + 1) % 8], 32'h0040_0113);
    check("ok_done", {31'd0, boot_done}, 1);
    check("ok_core_rst", {31'd0, core_rst}, 1);
    check("ok_err", {31'd0, boot_err}, 0);
`ifdef RISC_V_MIKE_BOOT_CHKSUM_EN
    do_reset();
    frame[11] = 8'hE2;
    send_frame(12, -1);
    repeat (20) @(negedge clk);
    check("badchk_err", {31'd0, boot_err}, 1);
    check("badchk_core_rst", {31'd0, core_rst}, 0);
    frame[11] = 8'hE3;
    send_frame(12, -1);
    repeat (20) @(negedge clk);
    check("resend_done", {31'd0, boot_done}, 1);
    check("resend_err", {31'd0, boot_err}, 0);
`endif
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    check("len255_err", {31'd0, boot_err}, 1);
    check("len255_we_count", we_total - base, 0);
    check("len255_core_rst", {31'd0, core_rst}, 0);
    do_reset();
    send_frame(5, 4);
    repeat (20) @(negedge clk);
    check("stop_low_err", {31'd0, boot_err}, 1);
    check("stop_low_done", {31'd0, boot_done}, 0);
    do_reset();
    send_frame(5, -1);
    repeat (TMO - 560) @(negedge clk);
    check("tmo_before_err", {31'd0, boot_err}, 0);
    repeat (700) @(negedge clk);
    check("tmo_after_err", {31'd0, boot_err}, 1);
    check("tmo_core_rst", {31'd0, core_rst}, 0);
    do_reset();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    check("len0_done", {31'd0, boot_done}, 1);
    check("len0_err", {31'd0, boot_err}, 0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    check("len0_we_count", we_total - base, 0);
    check("after_done_hold", {30'd0, boot_done, boot_err}, 32'd2);
    do_reset();
    send_frame(6, -1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_core_rst", {31'd0, core_rst}, 0);
    check("midrst_we", {31'd0, imem_we}, 0);
    check("midrst_addr", {24'd0, imem_addr}, 0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    base = we_total;
    send_frame(12, -1);
    repeat (20) @(negedge clk);
    check("midrst_we_count", we_total - base, 2);
    check("midrst_addr0", {24'd0, wa[base % 8]}, 2);
    check("midrst_data0", wd[base % 8], 32'h0020_0093);
    check("midrst_data1", wd[(base + 1) % 8], 32'h0040_0113);
    check("midrst_done", {31'd0, boot_done}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
